bin2bcd_seq: RTL

- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the calculator datapath.
- Takes the unsigned binary result from the ALU and produces packed BCD digits.
- Each 4-bit digit feeds one bcd_2seg display decoder.
- Codes 4'hA–4'hF are used deliberately as "blank" digits, which the display decoder turns off.

---
 rtl/bin2bcd_seq_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 121 ++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bus between a binary producer and the BCD converter.
// The master drives start/bin_in; the slave (converter) returns status and packed BCD digits.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start, bin_in,
        input  busy, done, ovf, bcd_out
    );

    modport slave (
        input  start, bin_in,
        output busy, done, ovf, bcd_out
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Latency BIN_W cycles from accept to done; start is ignored while busy (no queueing).
// Back-to-back conversions every BIN_W+1 cycles; bcd_out/ovf hold the previous result until done.
module bin2bcd_seq #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    bin2bcd_seq_if.slave  bus
);
    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    function automatic logic [63:0] max_value(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_value(DIGITS);

    logic [0:0]        state;
    logic [BIN_W-1:0]  bin_sr;
    logic [SCR_W-1:0]  scratch;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_pend;
    logic              done_r;
    logic              ovf_r;
    logic [SCR_W-1:0]  bcd_r;

    logic [SCR_W-1:0]        adj;
    logic [SCR_W+BIN_W-1:0]  shifted;
    logic [SCR_W-1:0]        next_scratch;
    logic [BIN_W-1:0]        next_bin;
    logic [SCR_W-1:0]        final_bcd;
    logic                    leading;
    logic [63:0]             bin_ext;

    assign bin_ext = 64'(bus.bin_in);

    // Per-nibble +3 correction, no carry across digits, then the combined shift.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        shifted      = {adj, bin_sr} << 1;
        next_scratch = shifted[BIN_W +: SCR_W];
        next_bin     = shifted[BIN_W-1:0];
    end

    // Blank leading zeros from the MSD down; digit 0 is always shown.
    always_comb begin
        final_bcd = next_scratch;
        leading   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (BLANK_LZ && leading && (final_bcd[4*k +: 4] == 4'h0)) begin
                final_bcd[4*k +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
        if (ovf_pend) begin
            final_bcd = '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            bin_sr   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            bcd_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        bin_sr   <= bus.bin_in;
                        scratch  <= '0;
                        cnt      <= '0;
                        ovf_pend <= (bin_ext > MAX_VAL);
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_sr  <= next_bin;
                    scratch <= next_scratch;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        state  <= S_IDLE;
                        done_r <= 1'b1;
                        bcd_r  <= final_bcd;
                        ovf_r  <= ovf_pend;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == S_SHIFT);
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;
    assign bus.bcd_out = bcd_r;
endmodule
